// File: rtl/rmt_pkg.sv
// Shared constants for the RMT action stage: container geometry, sub-action
// layout and ALU opcode encodings.
package rmt_pkg;

    localparam int C6B_W    = 48;
    localparam int C4B_W    = 32;
    localparam int C2B_W    = 16;
    localparam int NUM_CONT = 8;
    localparam int REMAIN_W = 356;
    localparam int ACT_LEN  = 25;
    localparam int NUM_SUB  = 25;   // sub-actions carried in one action word

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_SET  = 4'b1000;
    localparam logic [3:0] OP_KEEP = 4'b1011;

endpackage

// File: rtl/rmt_alu_cell.sv
// One container ALU (combinational).
//   opcode : sub_action[24:21] for this container
//   op1/op2: operands; op3: original container value (4B cells only)
//   result : op1 +/- op2 mod 2^W, op2 / op3 for set / keep when EN_4B_OPS,
//            otherwise op1
module rmt_alu_cell
    import rmt_pkg::*;
#(
    parameter int W         = 32,
    parameter bit EN_4B_OPS = 1'b0
) (
    input  logic [3:0]   opcode,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [W-1:0] op3,
    output logic [W-1:0] result
);

    always_comb begin
        result = op1;
        case (opcode)
            OP_ADD, OP_ADDI: result = op1 + op2;
            OP_SUB, OP_SUBI: result = op1 - op2;
            OP_SET:          if (EN_4B_OPS) result = op2;
            OP_KEEP:         if (EN_4B_OPS) result = op3;
            default:         result = op1;
        endcase
    end

endmodule

// File: rtl/action_alu_array.sv
// RMT action ALU array: 24 container ALUs, a compute register (S1) and a
// 2-entry output FIFO with valid/ready handoff.
//   clk, rst_n          : clock, synchronous reset (active HIGH despite name)
//   alu_in_*            : per-container operands, container i at [i*w +: w]
//   phv_remain_data     : untouched PHV remainder
//   action_in           : 25 sub-actions of 25 bits, opcode at [24:21]
//   alu_in_ready        : stage can accept this cycle
//   phv_out/_valid/_ready : output PHV {6B[7..0],4B[7..0],2B[7..0],remain}
//   drop_err            : sticky, valid presented while not ready
//   pkt_cnt             : PHVs handed downstream (wraps)
module action_alu_array
    import rmt_pkg::*;
#(
    parameter int STAGE    = 0,
    parameter int PHV_LEN  = 1124,
    parameter int ACT_LEN  = 25,
    parameter int width_2B = 16,
    parameter int width_4B = 32,
    parameter int width_6B = 48
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             alu_in_valid,
    input  logic [NUM_CONT*width_6B-1:0]     alu_in_6B_1,
    input  logic [NUM_CONT*width_6B-1:0]     alu_in_6B_2,
    input  logic [NUM_CONT*width_4B-1:0]     alu_in_4B_1,
    input  logic [NUM_CONT*width_4B-1:0]     alu_in_4B_2,
    input  logic [NUM_CONT*width_4B-1:0]     alu_in_4B_3,
    input  logic [NUM_CONT*width_2B-1:0]     alu_in_2B_1,
    input  logic [NUM_CONT*width_2B-1:0]     alu_in_2B_2,
    input  logic [REMAIN_W-1:0]              phv_remain_data,
    input  logic [NUM_SUB*ACT_LEN-1:0]       action_in,
    output logic                             alu_in_ready,
    output logic [PHV_LEN-1:0]               phv_out,
    output logic                             phv_out_valid,
    input  logic                             phv_out_ready,
    output logic                             drop_err,
    output logic [31:0]                      pkt_cnt
);

    localparam int OPC_LSB = ACT_LEN - 4;

    logic [NUM_CONT*width_6B-1:0] res_6b;
    logic [NUM_CONT*width_4B-1:0] res_4b;
    logic [NUM_CONT*width_2B-1:0] res_2b;

    // sub_action[0] and operand fields of each sub-action are not decoded here
    logic unused_bits;
    assign unused_bits = ^{action_in, 32'(STAGE)};

    genvar i;
    generate
        for (i = 0; i < NUM_CONT; i++) begin : g_cont
            rmt_alu_cell #(.W(width_6B), .EN_4B_OPS(1'b0)) u_alu_6b (
                .opcode (action_in[(17+i)*ACT_LEN + OPC_LSB +: 4]),
                .op1    (alu_in_6B_1[i*width_6B +: width_6B]),
                .op2    (alu_in_6B_2[i*width_6B +: width_6B]),
                .op3    ('0),
                .result (res_6b[i*width_6B +: width_6B])
            );
            rmt_alu_cell #(.W(width_4B), .EN_4B_OPS(1'b1)) u_alu_4b (
                .opcode (action_in[(9+i)*ACT_LEN + OPC_LSB +: 4]),
                .op1    (alu_in_4B_1[i*width_4B +: width_4B]),
                .op2    (alu_in_4B_2[i*width_4B +: width_4B]),
                .op3    (alu_in_4B_3[i*width_4B +: width_4B]),
                .result (res_4b[i*width_4B +: width_4B])
            );
            rmt_alu_cell #(.W(width_2B), .EN_4B_OPS(1'b0)) u_alu_2b (
                .opcode (action_in[(1+i)*ACT_LEN + OPC_LSB +: 4]),
                .op1    (alu_in_2B_1[i*width_2B +: width_2B]),
                .op2    (alu_in_2B_2[i*width_2B +: width_2B]),
                .op3    ('0),
                .result (res_2b[i*width_2B +: width_2B])
            );
        end
    endgenerate

    logic               s1_vld_q, s1_vld_d;
    logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d;
    logic [PHV_LEN-1:0] fifo_mem_q [2];
    logic [PHV_LEN-1:0] fifo_mem_d [2];
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;
    logic               drop_err_q, drop_err_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;
    logic [1:0]         occ;
    logic               accept, push, pop;

    always_comb begin
        occ          = 2'({1'b0, s1_vld_q} + fifo_cnt_q);
        alu_in_ready = (occ < 2'd2);
        accept       = alu_in_valid & alu_in_ready;
        pop          = (fifo_cnt_q != 2'd0) & phv_out_ready;
        // S1 drains whenever the FIFO has room, counting a same-cycle pop
        push         = s1_vld_q & ((fifo_cnt_q != 2'd2) | pop);

        s1_vld_d = accept | (s1_vld_q & ~push);
        s1_phv_d = accept ? {res_6b, res_4b, res_2b, phv_remain_data} : s1_phv_q;

        fifo_mem_d = fifo_mem_q;
        if (push) fifo_mem_d[wr_ptr_q] = s1_phv_q;
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        fifo_cnt_d = 2'(fifo_cnt_q + {1'b0, push} - {1'b0, pop});

        drop_err_d = drop_err_q | (alu_in_valid & ~alu_in_ready);
        pkt_cnt_d  = pkt_cnt_q + 32'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_vld_q      <= 1'b0;
            s1_phv_q      <= '0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            drop_err_q    <= 1'b0;
            pkt_cnt_q     <= 32'd0;
        end else begin
            s1_vld_q      <= s1_vld_d;
            s1_phv_q      <= s1_phv_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            drop_err_q    <= drop_err_d;
            pkt_cnt_q     <= pkt_cnt_d;
        end
    end

    assign phv_out       = fifo_mem_q[rd_ptr_q];
    assign phv_out_valid = (fifo_cnt_q != 2'd0);
    assign drop_err      = drop_err_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_action_alu_array.sv
module tb_action_alu_array;
    import rmt_pkg::*;

    localparam int PHV_LEN = 1124;
    localparam int OFF6 = 740;
    localparam int OFF4 = 484;
    localparam int OFF2 = 356;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                alu_in_valid;
    logic [383:0]        alu_in_6B_1, alu_in_6B_2;
    logic [255:0]        alu_in_4B_1, alu_in_4B_2, alu_in_4B_3;
    logic [127:0]        alu_in_2B_1, alu_in_2B_2;
    logic [355:0]        phv_remain_data;
    logic [624:0]        action_in;
    logic                alu_in_ready;
    logic [PHV_LEN-1:0]  phv_out;
    logic                phv_out_valid;
    logic                phv_out_ready;
    logic                drop_err;
    logic [31:0]         pkt_cnt;

    int checks = 0;
    int errors = 0;

    action_alu_array dut (
        .clk(clk), .rst_n(rst_n), .alu_in_valid(alu_in_valid),
        .alu_in_6B_1(alu_in_6B_1), .alu_in_6B_2(alu_in_6B_2),
        .alu_in_4B_1(alu_in_4B_1), .alu_in_4B_2(alu_in_4B_2), .alu_in_4B_3(alu_in_4B_3),
        .alu_in_2B_1(alu_in_2B_1), .alu_in_2B_2(alu_in_2B_2),
        .phv_remain_data(phv_remain_data), .action_in(action_in),
        .alu_in_ready(alu_in_ready), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
        .phv_out_ready(phv_out_ready), .drop_err(drop_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 = 6B, 1 = 4B, 2 = 2B, 3 = none
        int         idx;
        logic [3:0] opc;
        logic [47:0] op1, op2, op3, exp;
    } vec_t;
    vec_t vecs[12];

    localparam logic [355:0] REM = {4'hA, {11{32'h5A5A_0F0F}}};

    function automatic logic [47:0] b6_1(int i); return 48'h6100_0000_0000 + 48'(i); endfunction
    function automatic logic [47:0] b6_2(int i); return 48'h6200_0000_0000 + 48'(i); endfunction
    function automatic logic [31:0] b4_1(int i); return 32'h4100_0000 + 32'(i); endfunction
    function automatic logic [31:0] b4_2(int i); return 32'h4200_0000 + 32'(i); endfunction
    function automatic logic [31:0] b4_3(int i); return 32'h4300_0000 + 32'(i); endfunction
    function automatic logic [15:0] b2_1(int i); return 16'h2100 + 16'(i); endfunction
    function automatic logic [15:0] b2_2(int i); return 16'h2200 + 16'(i); endfunction
    function automatic logic [355:0] rem_p(int j); return {4'h0, 32'hC0DE_0000 + 32'(j), 320'h0}; endfunction

    // Expected PHV with every container equal to its base op1, one override
    function automatic logic [PHV_LEN-1:0] build_phv(int kind, int idx, logic [47:0] val,
                                                     logic [355:0] rem);
        logic [383:0] f6;
        logic [255:0] f4;
        logic [127:0] f2;
        for (int i = 0; i < 8; i++) begin
            f6[i*48 +: 48] = b6_1(i);
            f4[i*32 +: 32] = b4_1(i);
            f2[i*16 +: 16] = b2_1(i);
        end
        case (kind)
            0: f6[idx*48 +: 48] = val;
            1: f4[idx*32 +: 32] = val[31:0];
            2: f2[idx*16 +: 16] = val[15:0];
            default: ;
        endcase
        return {f6, f4, f2, rem};
    endfunction

    task automatic apply_base(logic [355:0] rem);
        for (int i = 0; i < 8; i++) begin
            alu_in_6B_1[i*48 +: 48] = b6_1(i);
            alu_in_6B_2[i*48 +: 48] = b6_2(i);
            alu_in_4B_1[i*32 +: 32] = b4_1(i);
            alu_in_4B_2[i*32 +: 32] = b4_2(i);
            alu_in_4B_3[i*32 +: 32] = b4_3(i);
            alu_in_2B_1[i*16 +: 16] = b2_1(i);
            alu_in_2B_2[i*16 +: 16] = b2_2(i);
        end
        phv_remain_data = rem;
        action_in = '0;
        action_in[21 +: 4] = 4'b0001;   // sub_action[0] must have no effect
    endtask

    task automatic set_cont(int kind, int idx, logic [3:0] opc,
                            logic [47:0] op1, logic [47:0] op2, logic [47:0] op3);
        case (kind)
            0: begin
                alu_in_6B_1[idx*48 +: 48] = op1;
                alu_in_6B_2[idx*48 +: 48] = op2;
                action_in[(17+idx)*25 + 21 +: 4] = opc;
            end
            1: begin
                alu_in_4B_1[idx*32 +: 32] = op1[31:0];
                alu_in_4B_2[idx*32 +: 32] = op2[31:0];
                alu_in_4B_3[idx*32 +: 32] = op3[31:0];
                action_in[(9+idx)*25 + 21 +: 4] = opc;
            end
            2: begin
                alu_in_2B_1[idx*16 +: 16] = op1[15:0];
                alu_in_2B_2[idx*16 +: 16] = op2[15:0];
                action_in[(1+idx)*25 + 21 +: 4] = opc;
            end
            default: ;
        endcase
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [359:0] act, logic [359:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_phv(string nm, logic [PHV_LEN-1:0] e);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.6B[%0d]", nm, i), 360'(phv_out[OFF6 + i*48 +: 48]), 360'(e[OFF6 + i*48 +: 48]));
            chk($sformatf("%s.4B[%0d]", nm, i), 360'(phv_out[OFF4 + i*32 +: 32]), 360'(e[OFF4 + i*32 +: 32]));
            chk($sformatf("%s.2B[%0d]", nm, i), 360'(phv_out[OFF2 + i*16 +: 16]), 360'(e[OFF2 + i*16 +: 16]));
        end
        chk($sformatf("%s.rem", nm), 360'(phv_out[355:0]), 360'(e[355:0]));
    endtask

    task automatic do_reset;
        rst_n = 1'b1;
        alu_in_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
    endtask

    // Single accept with ready=1: check T+1 empty, T+2 valid with expected data
    task automatic run_one(string nm, logic [PHV_LEN-1:0] e);
        chk({nm, ".ready"}, 360'(alu_in_ready), 360'(1));
        alu_in_valid = 1'b1;
        tick;
        alu_in_valid = 1'b0;
        chk({nm, ".t1_valid"}, 360'(phv_out_valid), 360'(0));
        tick;
        chk({nm, ".t2_valid"}, 360'(phv_out_valid), 360'(1));
        chk_phv(nm, e);
        tick;
    endtask

    initial begin
        logic [PHV_LEN-1:0] e;
        logic [PHV_LEN-1:0] exp_q[8];
        int sent, got, cyc;

        vecs[0]  = '{0, 3, 4'b0001, 48'h10,            48'h5, 48'h0,         48'h15};
        vecs[1]  = '{2, 0, 4'b0010, 48'h3,             48'h5, 48'h0,         48'hFFFE};
        vecs[2]  = '{1, 7, 4'b1000, 48'h1234,          48'hBEEF, 48'h0,      48'h0000BEEF};
        vecs[3]  = '{1, 2, 4'b1011, 48'h1,             48'h7, 48'hDEADBEEF,  48'hDEADBEEF};
        vecs[4]  = '{1, 5, 4'b0111, 48'h11223344,      48'h9, 48'h55,        48'h11223344};
        vecs[5]  = '{0, 7, 4'b1001, 48'hFFFF_FFFF_FFFF, 48'h2, 48'h0,        48'h1};
        vecs[6]  = '{0, 0, 4'b1000, 48'h123,           48'h456, 48'h0,       48'h123};
        vecs[7]  = '{2, 7, 4'b1010, 48'h0,             48'h1, 48'h0,         48'hFFFF};
        vecs[8]  = '{1, 0, 4'b0001, 48'hFFFFFFFF,      48'h1, 48'h0,         48'h0};
        vecs[9]  = '{2, 3, 4'b1011, 48'hABCD,          48'h1111, 48'h0,      48'hABCD};
        vecs[10] = '{1, 4, 4'b0010, 48'h100,           48'h1, 48'h0,         48'hFF};
        vecs[11] = '{0, 5, 4'b0000, 48'h777,           48'h888, 48'h0,       48'h777};

        phv_out_ready = 1'b1;
        apply_base(REM);
        do_reset;

        chk("rst.ready",    360'(alu_in_ready),  360'(1));
        chk("rst.valid",    360'(phv_out_valid), 360'(0));
        chk("rst.drop_err", 360'(drop_err),      360'(0));
        chk("rst.pkt_cnt",  360'(pkt_cnt),       360'(0));
        chk("rst.phv_zero", 360'(|phv_out),      360'(0));

        for (int v = 0; v < 12; v++) begin
            apply_base(REM);
            set_cont(vecs[v].kind, vecs[v].idx, vecs[v].opc, vecs[v].op1, vecs[v].op2, vecs[v].op3);
            run_one($sformatf("vec%0d", v),
                    build_phv(vecs[v].kind, vecs[v].idx, vecs[v].exp, REM));
        end

        // Two containers operated in one PHV
        apply_base(REM);
        set_cont(2, 0, 4'b0010, 48'h3, 48'h5, 48'h0);
        set_cont(1, 7, 4'b1000, 48'h1, 48'hBEEF, 48'h0);
        e = build_phv(2, 0, 48'hFFFE, REM);
        e[OFF4 + 7*32 +: 32] = 32'h0000BEEF;
        run_one("dual", e);
        chk("tbl.pkt_cnt",  360'(pkt_cnt),  360'(13));
        chk("tbl.drop_err", 360'(drop_err), 360'(0));

        // Backpressure: third back-to-back valid is dropped
        do_reset;
        phv_out_ready = 1'b0;
        apply_base(rem_p(0));
        chk("bp.rdy0", 360'(alu_in_ready), 360'(1));
        alu_in_valid = 1'b1;
        tick;
        apply_base(rem_p(1));
        chk("bp.rdy1", 360'(alu_in_ready), 360'(1));
        tick;
        apply_base(rem_p(2));
        chk("bp.rdy2_low", 360'(alu_in_ready), 360'(0));
        tick;
        alu_in_valid = 1'b0;
        chk("bp.drop_err", 360'(drop_err), 360'(1));
        chk("bp.rdy_full", 360'(alu_in_ready), 360'(0));
        tick;
        chk("bp.hold_valid", 360'(phv_out_valid), 360'(1));
        chk_phv("bp.hold", build_phv(3, 0, 48'h0, rem_p(0)));
        phv_out_ready = 1'b1;
        chk_phv("bp.out0", build_phv(3, 0, 48'h0, rem_p(0)));
        tick;
        chk("bp.valid1", 360'(phv_out_valid), 360'(1));
        chk_phv("bp.out1", build_phv(3, 0, 48'h0, rem_p(1)));
        tick;
        chk("bp.empty",   360'(phv_out_valid), 360'(0));
        chk("bp.pkt_cnt", 360'(pkt_cnt),       360'(2));

        // Continuous input with downstream always ready
        do_reset;
        phv_out_ready = 1'b1;
        for (int j = 0; j < 8; j++) exp_q[j] = build_phv(3, 0, 48'h0, rem_p(100 + j));
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 200) begin
            if (phv_out_valid) begin
                chk($sformatf("str.out%0d.rem", got), 360'(phv_out[355:0]), 360'(exp_q[got][355:0]));
                chk($sformatf("str.out%0d.6B7", got), 360'(phv_out[OFF6 + 7*48 +: 48]),
                    360'(exp_q[got][OFF6 + 7*48 +: 48]));
                got++;
            end
            if (alu_in_ready && sent < 8) begin
                apply_base(rem_p(100 + sent));
                alu_in_valid = 1'b1;
                sent++;
            end else begin
                alu_in_valid = 1'b0;
            end
            tick;
            cyc++;
        end
        alu_in_valid = 1'b0;
        chk("str.count",    360'(got),      360'(8));
        chk("str.drop_err", 360'(drop_err), 360'(0));
        chk("str.pkt_cnt",  360'(pkt_cnt),  360'(8));

        // Reset with two PHVs buffered and drop_err set
        phv_out_ready = 1'b0;
        apply_base(rem_p(200));
        alu_in_valid = 1'b1;
        tick;
        tick;
        tick;
        alu_in_valid = 1'b0;
        tick;
        chk("mr.pre_valid", 360'(phv_out_valid), 360'(1));
        chk("mr.pre_drop",  360'(drop_err),      360'(1));
        rst_n = 1'b1;
        tick;
        rst_n = 1'b0;
        chk("mr.valid",    360'(phv_out_valid), 360'(0));
        chk("mr.pkt_cnt",  360'(pkt_cnt),       360'(0));
        chk("mr.drop_err", 360'(drop_err),      360'(0));
        chk("mr.ready",    360'(alu_in_ready),  360'(1));
        chk("mr.phv_zero", 360'(|phv_out),      360'(0));
        phv_out_ready = 1'b1;
        tick;
        tick;
        tick;
        chk("mr.discard_valid", 360'(phv_out_valid), 360'(0));
        chk("mr.discard_cnt",   360'(pkt_cnt),       360'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
